// File: rtl/hbridge_coil_array_if.sv
// Gate/status bundle for the coil array: controller side is master,
// the coil model is slave.
interface hbridge_coil_array_if #(
  parameter int NCH   = 2,
  parameter int CUR_W = 13
);
  logic [NCH-1:0]       low_1;
  logic [NCH-1:0]       high_1;
  logic [NCH-1:0]       low_2;
  logic [NCH-1:0]       high_2;
  logic [NCH-1:0]       polarity_invert_config;
  logic                 fault_clr;
  logic [NCH*CUR_W-1:0] current;
  logic [NCH-1:0]       shoot_through;
  logic [NCH-1:0]       dt_viol;
  logic [NCH*8-1:0]     fault_cnt;

  modport master (
    output low_1, high_1, low_2, high_2, polarity_invert_config, fault_clr,
    input  current, shoot_through, dt_viol, fault_cnt
  );

  modport slave (
    input  low_1, high_1, low_2, high_2, polarity_invert_config, fault_clr,
    output current, shoot_through, dt_viol, fault_cnt
  );
endinterface

// File: rtl/hbridge_coil_array.sv
// H-bridge coil array model: per-channel gate decode, saturating current
// ramp/decay, shoot-through and dead-time monitors.

// One coil channel. Gate index map: 0=low_1 1=high_1 2=low_2 3=high_2,
// so the opposite switch on the same leg is index^1.
module hbridge_coil_lane #(
  parameter int CUR_W     = 13,
  parameter int RISE_STEP = 4,
  parameter int SLOW_STEP = 1,
  parameter int FAST_STEP = 8,
  parameter int ISAT      = 4095,
  parameter int DEAD_MIN  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_l1,
  input  logic                    i_h1,
  input  logic                    i_l2,
  input  logic                    i_h2,
  input  logic                    i_inv,
  input  logic                    i_clr,
  output logic signed [CUR_W-1:0] o_cur,
  output logic                    o_st,
  output logic                    o_dt,
  output logic [7:0]              o_cnt
);
  localparam int DW = $clog2(DEAD_MIN + 2);
  // Two guard bits so +/-step never overflows before the clamp.
  localparam int EW = CUR_W + 2;
  localparam logic signed [EW-1:0] L_RISE = EW'(RISE_STEP);
  localparam logic signed [EW-1:0] L_SLOW = EW'(SLOW_STEP);
  localparam logic signed [EW-1:0] L_FAST = EW'(FAST_STEP);
  localparam logic signed [EW-1:0] L_ISAT = EW'(ISAT);
  localparam logic [DW-1:0]        L_DMIN = DW'(DEAD_MIN);

  typedef enum logic [2:0] {M_FAULT, M_POS, M_NEG, M_SLOW, M_FAST} mode_e;

  logic signed [CUR_W-1:0] r_cur;
  logic                    r_st;
  logic                    r_dt;
  logic [7:0]              r_cnt;
  logic [3:0]              r_prev;
  logic [3:0][DW-1:0]      r_off;

  logic [3:0]              w_g;
  logic [3:0]              w_rise;
  logic [3:0][DW-1:0]      w_off_now;
  logic                    w_viol;
  logic                    w_fault;
  mode_e                   w_mode;
  logic signed [EW-1:0]    w_ext;
  logic signed [EW-1:0]    w_sum;
  logic signed [EW-1:0]    w_step;
  logic signed [EW-1:0]    w_nxt;

  assign w_g     = {i_h2, i_l2, i_h1, i_l1};
  assign w_fault = (i_h1 & i_l1) | (i_h2 & i_l2);

  // Gate decode in priority order; invert swaps the two drive directions.
  always_comb begin
    w_mode = M_SLOW;
    if (w_fault)                     w_mode = M_FAULT;
    else if (i_h1 & i_l2)            w_mode = i_inv ? M_NEG : M_POS;
    else if (i_h2 & i_l1)            w_mode = i_inv ? M_POS : M_NEG;
    else if (w_g == 4'b0000)         w_mode = M_FAST;
  end

  // Off-time per gate (falling-edge cycle = 0, saturating at DEAD_MIN) and
  // dead-time check on each rise. A rise against a gate that is on now is
  // a shoot-through, not a dead-time event.
  always_comb begin
    w_rise    = '0;
    w_off_now = '0;
    w_viol    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_rise[i] = w_g[i] & ~r_prev[i];
      if (w_g[i] || r_prev[i])    w_off_now[i] = '0;
      else if (r_off[i] >= L_DMIN) w_off_now[i] = L_DMIN;
      else                         w_off_now[i] = r_off[i] + 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (w_rise[i] && !w_g[i ^ 1] && (w_off_now[i ^ 1] < L_DMIN))
        w_viol = 1'b1;
    end
  end

  // Next current: clamp while driven, decay toward zero without overshoot.
  always_comb begin
    w_ext  = $signed({{2{r_cur[CUR_W-1]}}, r_cur});
    w_sum  = w_ext;
    w_step = (w_mode == M_FAST) ? L_FAST : L_SLOW;
    w_nxt  = w_ext;
    case (w_mode)
      M_POS: begin
        w_sum = w_ext + L_RISE;
        w_nxt = (w_sum > L_ISAT) ? L_ISAT : w_sum;
      end
      M_NEG: begin
        w_sum = w_ext - L_RISE;
        w_nxt = (w_sum < -L_ISAT) ? -L_ISAT : w_sum;
      end
      M_SLOW, M_FAST: begin
        if (w_ext > 0)      w_nxt = (w_ext < w_step)  ? '0 : w_ext - w_step;
        else if (w_ext < 0) w_nxt = (-w_ext < w_step) ? '0 : w_ext + w_step;
      end
      default: w_nxt = w_ext;
    endcase
  end

  // State update; a new fault or violation beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur  <= '0;
      r_st   <= 1'b0;
      r_dt   <= 1'b0;
      r_cnt  <= '0;
      r_prev <= '0;
      r_off  <= {4{L_DMIN}};
    end else begin
      r_cur  <= w_nxt[CUR_W-1:0];
      r_prev <= w_g;
      r_off  <= w_off_now;
      r_st   <= (r_st & ~i_clr) | w_fault;
      r_dt   <= (r_dt & ~i_clr) | w_viol;
      if (w_fault)    r_cnt <= i_clr ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
      else if (i_clr) r_cnt <= '0;
    end
  end

  assign o_cur = r_cur;
  assign o_st  = r_st;
  assign o_dt  = r_dt;
  assign o_cnt = r_cnt;
endmodule

module hbridge_coil_array #(
  parameter int NCH       = 2,
  parameter int CUR_W     = 13,
  parameter int RISE_STEP = 4,
  parameter int SLOW_STEP = 1,
  parameter int FAST_STEP = 8,
  parameter int ISAT      = 4095,
  parameter int DEAD_MIN  = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  hbridge_coil_array_if.slave  bus
);
  logic [NCH-1:0][CUR_W-1:0] w_cur;
  logic [NCH-1:0][7:0]       w_cnt;
  logic [NCH-1:0]            w_st;
  logic [NCH-1:0]            w_dt;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    hbridge_coil_lane #(
      .CUR_W(CUR_W), .RISE_STEP(RISE_STEP), .SLOW_STEP(SLOW_STEP),
      .FAST_STEP(FAST_STEP), .ISAT(ISAT), .DEAD_MIN(DEAD_MIN)
    ) u_lane (
      .clk   (clk),
      .resetn(resetn),
      .i_l1  (bus.low_1[n]),
      .i_h1  (bus.high_1[n]),
      .i_l2  (bus.low_2[n]),
      .i_h2  (bus.high_2[n]),
      .i_inv (bus.polarity_invert_config[n]),
      .i_clr (bus.fault_clr),
      .o_cur (w_cur[n]),
      .o_st  (w_st[n]),
      .o_dt  (w_dt[n]),
      .o_cnt (w_cnt[n])
    );
  end

  assign bus.current       = w_cur;
  assign bus.fault_cnt     = w_cnt;
  assign bus.shoot_through = w_st;
  assign bus.dt_viol       = w_dt;
endmodule

// File: doc/hbridge_coil_array.md
HBRIDGE_COIL_ARRAY -- requirements
Module: hbridge_coil_array

Interface
REQ-001 Parameter NCH, default 2: number of coil channels.
REQ-002 Parameter CUR_W, default 13: signed two's-complement current width per channel.
REQ-003 Parameter RISE_STEP, default 4: current change per cycle while driven.
REQ-004 Parameter SLOW_STEP, default 1: decay per cycle in slow decay.
REQ-005 Parameter FAST_STEP, default 8: decay per cycle in fast decay (all switches off).
REQ-006 Parameter ISAT, default 4095: current magnitude limit, ISAT <= 2^(CUR_W-1)-1.
REQ-007 Parameter DEAD_MIN, default 2: minimum off cycles between a leg's high and low switch.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 resetn  input  1  asynchronous, active-low reset.
REQ-010 low_1, high_1, low_2, high_2  input  NCH each  bridge switch gates, bit n = channel n, 1 = on.
REQ-011 polarity_invert_config  input  NCH  1 = swap the sign of the applied drive for that channel.
REQ-012 fault_clr  input  1  synchronous clear of all sticky flags and counters.
REQ-013 current  output  NCH*CUR_W  signed coil current; channel n occupies bits [n*CUR_W +: CUR_W].
REQ-014 shoot_through  output  NCH  sticky; set when a leg had high and low on together.
REQ-015 dt_viol  output  NCH  sticky; set on a dead-time violation.
REQ-016 fault_cnt  output  NCH*8  per-channel count of shoot-through cycles, saturating at 255.

Function
REQ-017 Each channel SHALL decode its gates every cycle into exactly one mode, evaluated in this priority: FAULT (high_x & low_x on either leg), POS (high_1 & low_2), NEG (high_2 & low_1), SLOW (both lows or both highs on), FAST (all four off). Any other combination is SLOW.
REQ-018 POS: current += RISE_STEP; NEG: current -= RISE_STEP. When polarity_invert_config[n]=1, POS and NEG swap.
REQ-019 Driven current SHALL saturate at +ISAT / -ISAT; it never wraps.
REQ-020 SLOW/FAST: current moves toward 0 by SLOW_STEP/FAST_STEP; if |current| < step, current becomes exactly 0 with no sign overshoot.
REQ-021 FAULT: current holds its value; shoot_through[n] sets; fault_cnt[n] increments by 1 per FAULT cycle, holding at 255.
REQ-022 Dead time: each leg tracks cycles since its high and low gates last went off, in a counter saturating at DEAD_MIN. dt_viol[n] SHALL set when a gate rises while the opposite gate on the same leg has been off for fewer than DEAD_MIN cycles, counting the falling-edge cycle as 0.
REQ-023 The dead-time counters SHALL start saturated, so the first gate rise after reset never flags.
REQ-024 A simultaneous high and low rise on one leg counts as FAULT only, not as dt_viol.
REQ-025 All outputs SHALL be registered; current reflects the gate inputs sampled on the previous rising edge, a latency of 1 cycle.
REQ-026 fault_clr SHALL clear shoot_through, dt_viol and fault_cnt on the next edge; current is unaffected.
REQ-027 If fault_clr and a new fault occur in the same cycle, the fault wins: flag = 1 and count = 1.
REQ-028 Channels SHALL be fully independent; a fault on one channel has no effect on any other.

Reset
REQ-029 resetn low SHALL immediately, without a clock, force current = 0, shoot_through = 0, dt_viol = 0, fault_cnt = 0, and dead-time counters = DEAD_MIN.
REQ-030 Reset asserted mid-ramp SHALL discard the accumulated current; after release, evolution restarts from 0.

Verification
REQ-031 Ch0 POS for 10 cycles, then FAST -> current0 reads 4, 8, ... 40, then 32, 24, 16, 8, 0, and holds 0.
REQ-032 Ch1 NEG for 1100 cycles with invert=0 -> current1 clamps at -4095; repeat with invert=1 -> clamps at +4095.
REQ-033 Ch0 current = 5, then SLOW for 7 cycles -> 4, 3, 2, 1, 0, 0, 0; no negative value appears.
REQ-034 Ch0 high_1 & low_1 for 300 cycles -> current held, shoot_through[0] = 1, fault_cnt0 = 255, ch1 untouched; then fault_clr together with one more fault cycle -> fault_cnt0 = 1.
REQ-035 Ch1 high_2 falls and low_2 rises 1 cycle later -> dt_viol[1] = 1; the same sequence with a 2-cycle gap -> dt_viol stays 0.
REQ-036 Assert resetn low asynchronously during a POS ramp at current 200 -> all outputs 0 before the next clock edge; after release, POS ramps from 4.
